// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states, slice controls.
// Flag outputs are built only when ALU_SERIAL_FLAGS_EN is defined.
package alu_serial_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SL_AND  = 2'b00,
        SL_OR   = 2'b01,
        SL_SUM  = 2'b10,
        SL_LESS = 2'b11
    } slice_op_e;

    typedef struct packed {
        logic      a_inv;
        logic      b_inv;
        slice_op_e op;
    } slice_ctrl_t;

    // Unsupported opcodes select the tied-low less input, so every bit comes out 0.
    function automatic slice_ctrl_t decode_ctrl(input logic [3:0] code);
        slice_ctrl_t c;
        c = '{a_inv: 1'b0, b_inv: 1'b0, op: SL_LESS};
        case (code)
            OP_AND: c.op = SL_AND;
            OP_OR:  c.op = SL_OR;
            OP_ADD: c.op = SL_SUM;
            OP_SUB, OP_SLT: begin
                c.b_inv = 1'b1;
                c.op    = SL_SUM;
            end
            OP_NOR: begin
                c.a_inv = 1'b1;
                c.b_inv = 1'b1;
                c.op    = SL_AND;
            end
            default: c.op = SL_LESS;
        endcase
        return c;
    endfunction

    function automatic logic needs_carry_in(input logic [3:0] code);
        return (code == OP_SUB) || (code == OP_SLT);
    endfunction

    function automatic logic is_arith(input logic [3:0] code);
        return (code == OP_ADD) || (code == OP_SUB);
    endfunction

    function automatic logic is_supported(input logic [3:0] code);
        return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
               (code == OP_SUB) || (code == OP_SLT) || (code == OP_NOR);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, full adder and a 4-way result select.
module alu_bit_slice
    import alu_serial_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      less,
    input  logic      a_invert,
    input  logic      b_invert,
    input  logic      cin,
    input  slice_op_e op,
    output logic      result,
    output logic      cout
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff = a ^ a_invert;
    assign b_eff = b ^ b_invert;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        result = less;
        case (op)
            SL_AND:  result = a_eff & b_eff;
            SL_OR:   result = a_eff | b_eff;
            SL_SUM:  result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one result bit per clock, LSB first, 33-edge latency.
// Define ALU_SERIAL_FLAGS_EN to build the zero/overflow flag outputs.
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       alu_ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic               c31_q;
    logic               s31_q;
    logic               busy_q;
    logic               done_q;

    slice_ctrl_t        ctrl;
    logic               slice_res;
    logic               slice_cout;
    logic               slt_bit;
    logic [WIDTH-1:0]   final_res;

    assign ctrl = decode_ctrl(op_q);

    alu_bit_slice u_slice (
        .a        (a_q[cnt]),
        .b        (b_q[cnt]),
        .less     (1'b0),
        .a_invert (ctrl.a_inv),
        .b_invert (ctrl.b_inv),
        .cin      (carry_q),
        .op       (ctrl.op),
        .result   (slice_res),
        .cout     (slice_cout)
    );

    // In FINISH carry_q holds the carry out of the MSB, so c31_q ^ carry_q is the overflow term.
    assign slt_bit   = s31_q ^ (c31_q ^ carry_q);
    assign final_res = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : res_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            c31_q   <= 1'b0;
            s31_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q    <= alu_ctrl_i;
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        res_q   <= '0;
                        cnt     <= '0;
                        carry_q <= needs_carry_in(alu_ctrl_i);
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_q[cnt] <= slice_res;
                    carry_q    <= slice_cout;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        c31_q <= carry_q;
                        s31_q <= slice_res;
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    res_q  <= final_res;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_q <= is_supported(op_q) && (final_res == '0);
                    ovf_q  <= is_arith(op_q) && (c31_q ^ carry_q);
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = res_q;

`ifdef ALU_SERIAL_FLAGS_EN
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
`else
    assign zero_o     = 1'b0;
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: cycle-level behavioural model plus directed literal cases.
// Honours ALU_SERIAL_FLAGS_EN the same way the design does.
module tb_alu_serial_ctrl;

`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif
    localparam int LATENCY = 33;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [3:0]  alu_ctrl_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .alu_ctrl_i (alu_ctrl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural result of one operation, straight from the opcode table.
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic z, output logic v);
        logic supported;
        supported = 1'b1;
        v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: begin
                r = 32'd0;
                supported = 1'b0;
            end
        endcase
        z = supported && (r == 32'd0);
        if (!FLAGS_EN) begin
            z = 1'b0;
            v = 1'b0;
        end
    endfunction

    int          m_remaining = 0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_zero = 1'b0;
    logic        exp_ovf = 1'b0;
    logic [31:0] pend_res;
    logic        pend_zero;
    logic        pend_ovf;

    // Reference timing: an accepted start completes a fixed number of edges later.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_remaining = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_res = '0;
            exp_zero = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_remaining == 0) begin
                if (start_i) begin
                    model_op(alu_ctrl_i, src1_i, src2_i, pend_res, pend_zero, pend_ovf);
                    m_remaining = LATENCY;
                    exp_busy = 1'b1;
                end
            end else begin
                m_remaining = m_remaining - 1;
                if (m_remaining == 0) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                    exp_res = pend_res;
                    exp_zero = pend_zero;
                    exp_ovf = pend_ovf;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (check_en) begin
            check_output("busy", {31'b0, busy_o}, {31'b0, exp_busy});
            check_output("done", {31'b0, done_o}, {31'b0, exp_done});
            if (!exp_busy) begin
                check_output("result", result_o, exp_res);
                check_output("zero", {31'b0, zero_o}, {31'b0, exp_zero});
                check_output("overflow", {31'b0, overflow_o}, {31'b0, exp_ovf});
            end
        end
    end

    // Drive one start at the next falling edge; the following rising edge accepts it.
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        alu_ctrl_i = op;
        src1_i = a;
        src2_i = b;
        @(posedge clk_i);
    endtask

    task automatic run_directed(input string name, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] lit_res,
                                input logic lit_zero, input logic lit_ovf);
        int lat;
        lat = -1;
        apply_stimulus(op, a, b);
        for (int e = 0; e < 40; e++) begin
            @(negedge clk_i);
            if (e == 0) start_i = 1'b0;
            if (done_o) begin
                lat = e;
                break;
            end
        end
        check_output({name, "_latency"}, 32'(lat), 32'(LATENCY));
        check_output({name, "_result"}, result_o, lit_res);
        check_output({name, "_zero"}, {31'b0, zero_o}, {31'b0, lit_zero & FLAGS_EN});
        check_output({name, "_overflow"}, {31'b0, overflow_o}, {31'b0, lit_ovf & FLAGS_EN});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 6))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b1100;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        int dones;
        $display("[TB] starting alu_serial_ctrl bench, flags %0d", FLAGS_EN);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_en = 1'b1;
        check_output("reset_busy", {31'b0, busy_o}, 32'd0);
        check_output("reset_result", result_o, 32'd0);
        rst_i = 1'b0;

        run_directed("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_directed("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        run_directed("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        run_directed("slt_ovf", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_directed("nor", 4'b1100, 32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);
        run_directed("or", 4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
        run_directed("and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
        run_directed("unsupported", 4'b1111, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);

        // A second start mid-operation must be ignored entirely.
        apply_stimulus(4'b0010, 32'd1, 32'd2);
        dones = 0;
        for (int e = 0; e < 45; e++) begin
            @(negedge clk_i);
            start_i = (e == 9);
            if (e == 9) begin
                alu_ctrl_i = 4'b0110;
                src1_i = 32'd100;
                src2_i = 32'd7;
            end
            if (done_o) begin
                dones++;
                check_output("ignore_result", result_o, 32'd3);
            end
        end
        start_i = 1'b0;
        check_output("ignore_done_count", 32'(dones), 32'd1);

        // Reset in the middle of an operation abandons it without a done pulse.
        apply_stimulus(4'b0010, 32'h0000_00FF, 32'h0000_0001);
        for (int e = 0; e < 15; e++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (e == 14) rst_i = 1'b1;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        check_output("midreset_busy", {31'b0, busy_o}, 32'd0);
        check_output("midreset_result", result_o, 32'd0);
        dones = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check_output("midreset_no_done", 32'(dones), 32'd0);
        run_directed("after_reset", 4'b0010, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);

        // Random traffic: starts at any time, including in the done cycle, plus rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            start_i = ($urandom_range(0, 3) == 0);
            alu_ctrl_i = pick_op();
            src1_i = pick_operand();
            src2_i = pick_operand();
            rst_i = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (fixed at 32 for this release).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request to begin an operation.
REQ-005 SHALL have port src1_i  input  32  operand A, captured on accepted start.
REQ-006 SHALL have port src2_i  input  32  operand B, captured on accepted start.
REQ-007 SHALL have port alu_ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; captured on accepted start.
REQ-008 SHALL have port busy_o  output  1  operation in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse: result and flags valid.
REQ-010 SHALL have port result_o  output  32  operation result, held until next accepted start.
REQ-011 SHALL have port zero_o  output  1  result_o == 0.
REQ-012 SHALL have port overflow_o  output  1  signed overflow for ADD/SUB.

Function
REQ-013 SHALL compute bit-serially, LSB first, one bit per clock through one 1-bit ALU slice (inputs a, b, less, a_invert, b_invert, cin, 2-bit op; outputs result, cout).
REQ-014 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE.
REQ-015 SHALL accept start_i only in IDLE; start_i in RUN/FINISH is ignored, and captured operands/opcode are not modified.
REQ-016 SHALL, on accept: latch operands/opcode, clear result register and bit counter, load carry register with 1 for SUB/SLT (0 otherwise), enter RUN.
REQ-017 SHALL, in RUN, drive the slice with bit[cnt] of each operand and carry register; store slice result in result bit[cnt]; update carry register from cout; increment cnt; leave RUN after cnt = 31.
REQ-018 SHALL map opcodes to slice controls {a_inv, b_inv, op}: AND {0,0,00}, OR {0,0,01}, ADD {0,0,10}, SUB {0,1,10}, SLT {0,1,10}, NOR {1,1,00}.
REQ-019 SHALL record carry-into-bit-31 and sum bit 31 during the cnt = 31 cycle.
REQ-020 SHALL, in FINISH: for SLT, write result = {31'b0, sum31 ^ overflow}; compute zero and overflow flags; assert done_o for exactly one cycle on return to IDLE.
REQ-021 SHALL assert overflow_o only for ADD/SUB (carry into bit 31 XOR carry out of bit 31); 0 for all other opcodes.
REQ-022 SHALL have latency 33 rising edges: accepting edge = 0; done_o high after edge 33; busy_o high after edges 0 through 32 inclusive, low once done_o is high.
REQ-023 SHALL treat unsupported opcodes as producing result 0, flags 0, with normal 33-edge latency.
REQ-024 SHALL allow start_i in the same cycle done_o is high (FSM is IDLE); that start is accepted.

Reset
REQ-025 SHALL, when rst_i is high at a rising edge, enter IDLE and clear busy_o, done_o, result_o, zero_o, overflow_o, carry register and counter; any operation in progress is abandoned without done_o.
REQ-026 SHALL give rst_i priority over start_i in the same edge.

Configuration
REQ-027 SHALL, with ALU_SERIAL_FLAGS_EN defined, implement zero_o and overflow_o per REQ-020/021.
REQ-028 SHALL, without ALU_SERIAL_FLAGS_EN, tie zero_o and overflow_o to 0 and omit flag logic; the SLT overflow term is still computed internally; result and timing are unchanged.

Structure
REQ-029 SHALL place opcode constants, FSM state encoding, slice op encoding and WIDTH default in shared package alu_serial_pkg.
REQ-030 SHALL instantiate exactly one sub-module, alu_bit_slice (the 1-bit slice of REQ-013).

Verification
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, zero 0, done_o 33 edges after start.
REQ-032 SUB 0x00000005 - 0x00000005 -> result 0x00000000, zero 1, overflow 0.
REQ-033 SLT 0xFFFFFFFF vs 0x00000001 -> result 0x00000001; SLT 0x80000000 vs 0x7FFFFFFF -> 0x00000001 (overflow-corrected).
REQ-034 NOR 0x00000000, 0x0000FFFF -> result 0xFFFF0000; OR/AND spot values correct.
REQ-035 start_i pulsed at edge 10 of a running op with different operands -> ignored; first result unchanged; one done_o only.
REQ-036 rst_i at edge 15 of a running op -> all outputs 0, no done_o; new start afterward completes correctly.
